// File: rtl/jtdd_colmix.sv
// Colour mixer: layer priority select, 1024x8 dual-port palette, RGB output
// stage with blanking, and a matching blank-signal delay line.
module jtdd_colmix #(
    parameter int unsigned BLANK_DLY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic [7:0] char_pxl,
    input  logic [7:0] obj_pxl,
    input  logic [7:0] scr_pxl,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [2:0] gfx_en,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    // Lower half holds {green,red}; upper half holds blue (upper nibble reads as 0).
    logic [7:0] pal_gr [0:511];
    logic [3:0] pal_b  [0:511];

    logic [8:0]           sel_idx;
    logic [8:0]           idx1;
    logic [7:0]           gr2;
    logic [3:0]           b2;
    logic [BLANK_DLY-1:0] hb_sr;
    logic [BLANK_DLY-1:0] vb_sr;
    logic                 blank_ok;

    // CPU port: write on strobe, registered read every clk.
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_wrn) begin
            if (cpu_AB[9]) pal_b[cpu_AB[8:0]]  <= cpu_dout[3:0];
            else           pal_gr[cpu_AB[8:0]] <= cpu_dout;
        end
        pal_dout <= cpu_AB[9] ? {4'b0, pal_b[cpu_AB[8:0]]} : pal_gr[cpu_AB[8:0]];
    end

    // Layer priority: char over obj over scroll; index 0 when nothing selected.
    always_comb begin
        sel_idx = '0;
        if (gfx_en[0] && char_pxl[3:0] != 4'd0)
            sel_idx = {1'b0, char_pxl};
        else if (gfx_en[2] && obj_pxl[3:0] != 4'd0)
            sel_idx = 9'h080 + {1'b0, obj_pxl};
        else if (gfx_en[1])
            sel_idx = 9'h100 + {1'b0, scr_pxl};
    end

    // Blank for the pixel entering the output stage is one step behind the
    // end of the delay line, so RGB and *_dly change in the same tick.
    assign blank_ok = hb_sr[BLANK_DLY-2] && vb_sr[BLANK_DLY-2];

    // Three-stage pixel pipeline and blank delay line, advancing on pxl_cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx1  <= '0;
            gr2   <= '0;
            b2    <= '0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hb_sr <= '0;
            vb_sr <= '0;
        end else if (pxl_cen) begin
            idx1  <= sel_idx;
            gr2   <= pal_gr[idx1];
            b2    <= pal_b[idx1];
            red   <= blank_ok ? gr2[3:0] : 4'd0;
            green <= blank_ok ? gr2[7:4] : 4'd0;
            blue  <= blank_ok ? b2       : 4'd0;
            hb_sr <= {hb_sr[BLANK_DLY-2:0], LHBL};
            vb_sr <= {vb_sr[BLANK_DLY-2:0], LVBL};
        end
    end

    assign LHBL_dly = hb_sr[BLANK_DLY-1];
    assign LVBL_dly = vb_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtdd_colmix.sv
// Directed bench for jtdd_colmix: priority, palette halves, latency,
// blanking alignment, clock-enable hold, write/read collision and reset.
module tb_jtdd_colmix;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic [7:0] char_pxl, obj_pxl, scr_pxl;
    logic       LHBL, LVBL;
    logic [2:0] gfx_en;
    logic [9:0] cpu_AB;
    logic       pal_cs, cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    int unsigned errors = 0;
    int unsigned checks = 0;

    jtdd_colmix #(.BLANK_DLY(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .gfx_en   (gfx_en),
        .cpu_AB   (cpu_AB),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
        cpu_AB   = a;
        cpu_dout = d;
        pal_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        tick(1);
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
    endtask

    function automatic logic [15:0] rgb();
        return {4'h0, red, green, blue};
    endfunction

    initial begin
        rst = 1'b1; pxl_cen = 1'b1;
        char_pxl = '0; obj_pxl = '0; scr_pxl = '0;
        LHBL = 1'b1; LVBL = 1'b1; gfx_en = 3'b111;
        cpu_AB = '0; pal_cs = 1'b0; cpu_wrn = 1'b1; cpu_dout = '0;
        tick(2);
        check("rst_rgb",  rgb(), 16'h000);
        check("rst_hdly", {15'd0, LHBL_dly}, 16'd0);
        check("rst_vdly", {15'd0, LVBL_dly}, 16'd0);

        rst = 1'b0; pxl_cen = 1'b0;
        cpu_wr(10'h013, 8'h5A); cpu_wr(10'h213, 8'h07);
        cpu_wr(10'h0A5, 8'h3C); cpu_wr(10'h2A5, 8'h09);
        cpu_wr(10'h131, 8'hE1); cpu_wr(10'h331, 8'h02);
        cpu_wr(10'h000, 8'h4B); cpu_wr(10'h200, 8'h0D);
        cpu_wr(10'h085, 8'h12); cpu_wr(10'h285, 8'h03);
        cpu_AB = 10'h213; tick(1);
        check("cpu_rd_blue", {8'd0, pal_dout}, 16'h0007);
        cpu_AB = 10'h0A5; tick(1);
        check("cpu_rd_gr", {8'd0, pal_dout}, 16'h003C);
        check("hold_while_cpu", rgb(), 16'h000);

        // Char entry 0x013 with all layers on; 3-tick latency.
        pxl_cen = 1'b1; char_pxl = 8'h13; obj_pxl = 8'h00; scr_pxl = 8'h31;
        tick(2);
        check("lat_rgb_t2",  rgb(), 16'h000);
        check("lat_hdly_t2", {15'd0, LHBL_dly}, 16'd0);
        tick(1);
        check("char_013", rgb(), 16'h0A57);
        check("hdly_t3", {15'd0, LHBL_dly}, 16'd1);
        check("vdly_t3", {15'd0, LVBL_dly}, 16'd1);

        // Priority selection.
        char_pxl = 8'h10; obj_pxl = 8'h25; scr_pxl = 8'h31; gfx_en = 3'b111;
        tick(3); check("obj_0A5", rgb(), 16'h0C39);
        gfx_en = 3'b011;
        tick(3); check("scr_131", rgb(), 16'h01E2);
        gfx_en = 3'b000;
        tick(3); check("none_000", rgb(), 16'h0B4D);
        char_pxl = 8'h13; gfx_en = 3'b110;
        tick(3); check("char_off_obj", rgb(), 16'h0C39);
        gfx_en = 3'b111;
        tick(3); check("char_back", rgb(), 16'h0A57);

        // One-tick horizontal blank.
        LHBL = 1'b0; tick(1); LHBL = 1'b1;
        tick(1);
        check("hb_pre_rgb",  rgb(), 16'h0A57);
        check("hb_pre_dly",  {15'd0, LHBL_dly}, 16'd1);
        tick(1);
        check("hb_rgb",      rgb(), 16'h0000);
        check("hb_dly",      {15'd0, LHBL_dly}, 16'd0);
        tick(1);
        check("hb_post_rgb", rgb(), 16'h0A57);
        check("hb_post_dly", {15'd0, LHBL_dly}, 16'd1);

        // Clock enable held low with moving inputs.
        pxl_cen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            char_pxl = 8'($urandom); obj_pxl = 8'($urandom); scr_pxl = 8'($urandom);
            LHBL = i[0]; LVBL = i[1];
            tick(1);
            check("cen_hold_rgb", rgb(), 16'h0A57);
            check("cen_hold_dly", {14'd0, LHBL_dly, LVBL_dly}, 16'h0003);
        end
        char_pxl = 8'h10; obj_pxl = 8'h25; scr_pxl = 8'h31; LHBL = 1'b1; LVBL = 1'b1;
        pxl_cen = 1'b1;
        tick(2); check("resume_t2", rgb(), 16'h0A57);
        tick(1); check("resume_t3", rgb(), 16'h0C39);

        // Palette write colliding with the video read of entry 0x085.
        obj_pxl = 8'h05;
        tick(1);
        cpu_AB = 10'h085; cpu_dout = 8'h76; pal_cs = 1'b1; cpu_wrn = 1'b0;
        tick(1);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
        tick(1); check("collide_old", rgb(), 16'h0213);
        tick(1); check("collide_new", rgb(), 16'h0673);

        // Single-clk reset mid-line with pxl_cen low.
        pxl_cen = 1'b0; rst = 1'b1;
        tick(1);
        check("mid_rst_rgb",  rgb(), 16'h0000);
        check("mid_rst_dly",  {14'd0, LHBL_dly, LVBL_dly}, 16'h0000);
        rst = 1'b0; cpu_AB = 10'h013;
        tick(1);
        check("pal_kept", {8'd0, pal_dout}, 16'h005A);
        pxl_cen = 1'b1;
        tick(2); check("post_rst_t2", rgb(), 16'h0000);
        tick(1); check("post_rst_t3", rgb(), 16'h0673);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
